eth_tx_fcs_ctrl: RTL and testbench

ETH_TX_FCS_CTRL -- requirements
Module: eth_tx_fcs_ctrl

---
 rtl/eth_pkg.sv | 28 ++
 rtl/eth_crc32_byte.sv | 22 ++
 rtl/eth_tx_fcs_ctrl.sv | 135 +++++++++++++
 tb/tb_eth_tx_fcs_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types, constants and the byte-wise CRC-32 step for the Ethernet TX FCS path.
// Combinational helpers only; no latency and no flow control live here.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAD  = 2'd2,
    ST_FCS  = 2'd3
  } state_t;

  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [15:0] MIN_FRAME_LEN = 16'd60;
  localparam logic [2:0]  FCS_LEN       = 3'd4;

  // Reflected CRC-32: byte is folded into the low bits, then shifted out LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Registered CRC-32 accumulator: one byte per cycle when en, init reloads the seed.
// Result visible one cycle after en; no backpressure, the caller gates en.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// Ethernet TX framer: forwards payload, optional zero pad (ETH_TX_PAD_EN) and appends the FCS.
// One registered output slot, 1-cycle latency; s_ready follows the slot, held low during pad/FCS.
module eth_tx_fcs_ctrl
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_len
);

  state_t      state, state_nxt;
  logic [15:0] byte_cnt;
  logic [2:0]  fcs_idx;
  logic [31:0] crc;
  logic [31:0] crc_n;
  logic        slot_free;
  logic        final_hs;
  logic [15:0] cnt_base;
  logic [15:0] cnt_inc;
  logic [16:0] len_sum;
  logic        load;
  logic [7:0]  load_data;
  logic        load_last;
  logic        cnt_en;

  assign slot_free = !m_valid || m_ready;
  assign final_hs  = (state == ST_FCS) && m_valid && m_ready && m_last;
  assign crc_n     = ~crc;
  // Counter restarts with the first byte of every frame.
  assign cnt_base  = (state == ST_IDLE) ? 16'd0 : byte_cnt;
  assign cnt_inc   = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
  assign len_sum   = {1'b0, byte_cnt} + {14'd0, FCS_LEN};

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    load      = 1'b0;
    load_data = 8'h00;
    load_last = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE, ST_DATA: begin
        s_ready = !rst && slot_free;
        if (s_valid && s_ready) begin
          load      = 1'b1;
          load_data = s_data;
          cnt_en    = 1'b1;
          if (s_last) begin
`ifdef ETH_TX_PAD_EN
            state_nxt = (cnt_inc < MIN_FRAME_LEN) ? ST_PAD : ST_FCS;
`else
            state_nxt = ST_FCS;
`endif
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        if (slot_free) begin
          load   = 1'b1;
          cnt_en = 1'b1;
          if (cnt_inc >= MIN_FRAME_LEN) state_nxt = ST_FCS;
        end
      end
`endif
      ST_FCS: begin
        // The last FCS byte must be taken before the slot is released to a new frame.
        if (final_hs) begin
          state_nxt = ST_IDLE;
        end else if (slot_free && (fcs_idx != FCS_LEN)) begin
          load      = 1'b1;
          load_data = crc_n[{fcs_idx[1:0], 3'b000} +: 8];
          load_last = (fcs_idx == FCS_LEN - 3'd1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= 16'd0;
      fcs_idx    <= 3'd0;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= 16'd0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= final_hs;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_last  <= load_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (cnt_en) byte_cnt <= cnt_inc;
      if (state != ST_FCS) begin
        fcs_idx <= 3'd0;
      end else if (load) begin
        fcs_idx <= fcs_idx + 3'd1;
      end
      if (final_hs) frame_len <= len_sum[16] ? 16'hFFFF : len_sum[15:0];
    end
  end

  // CRC covers payload and pad only; FCS bytes are loaded with cnt_en low.
  eth_crc32_byte u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (final_hs),
    .en   (load && cnt_en),
    .data (load_data),
    .crc  (crc)
  );

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Self-checking bench for eth_tx_fcs_ctrl: vector table plus hand-written back-to-back,
// reset-abort and long-frame sequences, checked by a byte scoreboard and receiver residue.
module tb_eth_tx_fcs_ctrl;

`ifdef ETH_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_len;

  eth_tx_fcs_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_len  (frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [8:0]  sbq[$];
  logic [15:0] lenq[$];
  bit          bp_rand = 1'b0;
  bit          chk_pending = 1'b0;
  logic [7:0]  chk_byte = 8'h00;
  int          done_cnt = 0;
  logic [31:0] last4 = 32'h0;
  bit          gap_en = 1'b0;
  int          gap_run = 0;
  int          gaps = 0;
  int          max_gap = 0;

  typedef struct {
    int          len;
    int          kind;
    bit          bp;
    logic [15:0] exp_len;
    bit          has_fcs;
    logic [31:0] exp_fcs;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic consume_latency();
    if (chk_pending) begin
      check("latency_vld", {31'd0, m_valid}, 32'd1);
      check("latency_dat", {24'd0, m_data}, {24'd0, chk_byte});
      chk_pending = 1'b0;
    end
  endtask

  // Downstream ready: constant high or a fresh coin flip each cycle.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, hold-while-stalled, residue and frame_done checks.
  initial begin
    bit          prev_stall;
    bit          prev_done;
    logic [7:0]  prev_d;
    logic        prev_l;
    logic [31:0] rx_crc;
    logic [8:0]  exp_b;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_d     = 8'h00;
    prev_l     = 1'b0;
    rx_crc     = 32'hFFFFFFFF;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        rx_crc     = 32'hFFFFFFFF;
      end else begin
        if (prev_stall) begin
          check("stall_hold", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, prev_l, prev_d});
        end
        if (m_valid && m_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_byte", {23'd0, m_last, m_data}, 32'hFFFFFFFF);
          end else begin
            exp_b = sbq.pop_front();
            check("sb_byte", {23'd0, m_last, m_data}, {23'd0, exp_b});
          end
          rx_crc = crc_upd(rx_crc, m_data);
          last4  = {m_data, last4[31:8]};
          if (m_last) begin
            check("fcs_residue", rx_crc, 32'hDEBB20E3);
            rx_crc = 32'hFFFFFFFF;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_d     = m_data;
        prev_l     = m_last;
        if (frame_done) begin
          done_cnt++;
          check("done_width", {31'd0, prev_done}, 32'd0);
          if (lenq.size() == 0) check("unexpected_done", {16'd0, frame_len}, 32'hFFFFFFFF);
          else check("frame_len", {16'd0, frame_len}, {16'd0, lenq.pop_front()});
        end
        prev_done = frame_done;
      end
    end
  end

  // Measures s_ready-low runs seen while a byte is being offered.
  initial begin
    forever begin
      @(negedge clk);
      if (gap_en) begin
        if (s_valid && !s_ready) begin
          gap_run++;
        end else if (gap_run > 0) begin
          gaps++;
          if (gap_run > max_gap) max_gap = gap_run;
          gap_run = 0;
        end
      end
    end
  end

  task automatic send_frame(input int len, input int kind, input logic [15:0] exp_len,
                            input int abort_after, input bit sync);
    logic [7:0]  pl[$];
    logic [31:0] c;
    string       kat;
    int          n;
    kat = "123456789";
    for (int i = 0; i < len; i++) begin
      case (kind)
        0:       pl.push_back(kat[i % 9]);
        1:       pl.push_back(8'hAA);
        2:       pl.push_back(i[7:0]);
        default: pl.push_back(8'($urandom));
      endcase
    end
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c = crc_upd(c, pl[i]);
      sbq.push_back({1'b0, pl[i]});
    end
    n = len;
    while (PAD_ON && n < 60) begin
      c = crc_upd(c, 8'h00);
      sbq.push_back(9'h000);
      n++;
    end
    c = ~c;
    for (int b = 0; b < 4; b++) sbq.push_back({(b == 3), c[8*b +: 8]});
    lenq.push_back(exp_len);
    if (sync) begin
      @(negedge clk);
      consume_latency();
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < len; i++) begin
      int w;
      s_valid = 1'b1;
      s_data  = pl[i];
      s_last  = (i == len - 1);
      w = 0;
      forever begin
        @(negedge clk);
        consume_latency();
        if (s_ready) break;
        w++;
        if (w > 2000) break;
      end
      if (!s_ready) begin
        check("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      chk_pending = 1'b1;
      chk_byte    = pl[i];
      if (abort_after > 0 && i + 1 == abort_after) break;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int w;
    w = 0;
    while ((sbq.size() != 0 || lenq.size() != 0) && w < budget) begin
      @(negedge clk);
      consume_latency();
      w++;
    end
    check("drain_done", {31'd0, (w < budget)}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0;
    vecs[0] = '{9,   0, 1'b0, PAD_ON ? 16'd64 : 16'd13, !PAD_ON, 32'hCBF43926};
    vecs[1] = '{1,   1, 1'b0, PAD_ON ? 16'd64 : 16'd5,  1'b0,    32'h0};
    vecs[2] = '{100, 3, 1'b1, 16'd104,                  1'b0,    32'h0};
    vecs[3] = '{59,  2, 1'b0, PAD_ON ? 16'd64 : 16'd63, 1'b0,    32'h0};
    vecs[4] = '{60,  2, 1'b1, 16'd64,                   1'b0,    32'h0};
    vecs[5] = '{61,  3, 1'b0, 16'd65,                   1'b0,    32'h0};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid",    {31'd0, m_valid},    32'd0);
    check("rst_m_data",     {24'd0, m_data},     32'd0);
    check("rst_m_last",     {31'd0, m_last},     32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_len",  {16'd0, frame_len},  32'd0);
    check("rst_s_ready",    {31'd0, s_ready},    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

    for (int k = 0; k < 6; k++) begin
      bp_rand = vecs[k].bp;
      send_frame(vecs[k].len, vecs[k].kind, vecs[k].exp_len, 0, 1'b1);
      wait_drain(5000);
      if (vecs[k].has_fcs) check("kat_fcs", last4, vecs[k].exp_fcs);
    end
    bp_rand = 1'b0;

    // Back-to-back frames with s_valid held across the boundary.
    d0      = done_cnt;
    gaps    = 0;
    max_gap = 0;
    gap_run = 0;
    gap_en  = 1'b1;
    send_frame(64, 2, 16'd68, 0, 1'b1);
    send_frame(64, 3, 16'd68, 0, 1'b0);
    wait_drain(5000);
    gap_en = 1'b0;
    check("b2b_gap_count", gaps, 32'd1);
    check("b2b_gap_ge4", {31'd0, (max_gap >= 4)}, 32'd1);
    check("b2b_done_count", done_cnt - d0, 32'd2);

    // Reset after the 20th accepted byte discards the frame.
    d0 = done_cnt;
    send_frame(40, 2, 16'd44, 20, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_hold_s_ready", {31'd0, s_ready}, 32'd0);
    chk_pending = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    lenq.delete();
    @(negedge clk);
    check("abort_m_valid", {31'd0, m_valid}, 32'd0);
    check("abort_busy",    {31'd0, busy},    32'd0);
    check("abort_s_ready", {31'd0, s_ready}, 32'd1);
    send_frame(30, 3, PAD_ON ? 16'd64 : 16'd34, 0, 1'b1);
    wait_drain(5000);
    check("abort_done_count", done_cnt - d0, 32'd1);

    // Long frame: length saturates, FCS still checked by scoreboard and residue.
    send_frame(70000, 3, 16'hFFFF, 0, 1'b1);
    wait_drain(5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
